// File: rtl/branch_resolve.sv
// Execute-stage branch resolution with a bimodal (2-bit counter) predictor and a one-deep result register.
// Optional statistics counters are enabled by defining BRANCH_RESOLVE_STATS_EN.
module branch_resolve #(
    parameter int         XLEN        = 32,
    parameter int         BHT_ENTRIES = 64,
    parameter logic [1:0] CTR_INIT    = 2'b01,
    parameter int         STAT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   pred_pc,
    output logic              pred_taken,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [2:0]        ex_funct3,
    input  logic [XLEN-1:0]   ex_rs1,
    input  logic [XLEN-1:0]   ex_rs2,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic [XLEN-1:0]   ex_imm,
    input  logic              ex_pred_taken,
    input  logic              flush,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_taken,
    output logic [XLEN-1:0]   res_target,
    output logic [XLEN-1:0]   res_redirect,
    output logic              res_mispredict,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispred
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]      bht_q [BHT_ENTRIES];
    logic [1:0]      bht_d [BHT_ENTRIES];
    logic            res_valid_q, res_valid_d;
    logic            res_taken_q, res_taken_d;
    logic [XLEN-1:0] res_target_q, res_target_d;
    logic [XLEN-1:0] res_redirect_q, res_redirect_d;
    logic            res_mispredict_q, res_mispredict_d;

    logic             accept;
    logic             legal;
    logic             taken_c;
    logic             mispredict_c;
    logic [XLEN-1:0]  target_c;
    logic [XLEN-1:0]  redirect_c;
    logic [IDX_W-1:0] ex_idx;
    logic [1:0]       ctr_old;

    // Only the word-index bits of the fetch PC select a BHT entry.
    logic unused_pred_bits;
    assign unused_pred_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0]};

    assign pred_taken = bht_q[pred_pc[IDX_W+1:2]][1];
    assign ex_ready   = !res_valid_q || res_ready;
    assign accept     = ex_valid && ex_ready && !flush;

    always_comb begin
        legal   = 1'b1;
        taken_c = 1'b0;
        case (ex_funct3)
            3'b000:  taken_c = (ex_rs1 == ex_rs2);
            3'b001:  taken_c = (ex_rs1 != ex_rs2);
            3'b100:  taken_c = ($signed(ex_rs1) <  $signed(ex_rs2));
            3'b101:  taken_c = ($signed(ex_rs1) >= $signed(ex_rs2));
            3'b110:  taken_c = (ex_rs1 <  ex_rs2);
            3'b111:  taken_c = (ex_rs1 >= ex_rs2);
            default: legal   = 1'b0;
        endcase
        target_c     = ex_pc + ex_imm;
        redirect_c   = taken_c ? target_c : ex_pc + XLEN'(4);
        mispredict_c = (taken_c != ex_pred_taken);
        ex_idx       = ex_pc[IDX_W+1:2];
        ctr_old      = bht_q[ex_idx];
    end

    always_comb begin
        bht_d = bht_q;
        if (accept && legal) begin
            if (taken_c && ctr_old != 2'b11)
                bht_d[ex_idx] = ctr_old + 2'b01;
            else if (!taken_c && ctr_old != 2'b00)
                bht_d[ex_idx] = ctr_old - 2'b01;
        end
    end

    always_comb begin
        res_valid_d      = res_valid_q;
        res_taken_d      = res_taken_q;
        res_target_d     = res_target_q;
        res_redirect_d   = res_redirect_q;
        res_mispredict_d = res_mispredict_q;
        if (flush) begin
            res_valid_d = 1'b0;
        end else if (accept) begin
            res_valid_d      = 1'b1;
            res_taken_d      = taken_c;
            res_target_d     = target_c;
            res_redirect_d   = redirect_c;
            res_mispredict_d = mispredict_c;
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CTR_INIT;
            res_valid_q      <= 1'b0;
            res_taken_q      <= 1'b0;
            res_target_q     <= '0;
            res_redirect_q   <= '0;
            res_mispredict_q <= 1'b0;
        end else begin
            bht_q            <= bht_d;
            res_valid_q      <= res_valid_d;
            res_taken_q      <= res_taken_d;
            res_target_q     <= res_target_d;
            res_redirect_q   <= res_redirect_d;
            res_mispredict_q <= res_mispredict_d;
        end
    end

    assign res_valid      = res_valid_q;
    assign res_taken      = res_taken_q;
    assign res_target     = res_target_q;
    assign res_redirect   = res_redirect_q;
    assign res_mispredict = res_mispredict_q;

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [STAT_W-1:0] stat_branches_q, stat_branches_d;
    logic [STAT_W-1:0] stat_mispred_q, stat_mispred_d;

    // Illegal encodings are resolved but deliberately left out of the counts.
    always_comb begin
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;
        if (accept && legal) begin
            if (stat_branches_q != '1)
                stat_branches_d = stat_branches_q + STAT_W'(1);
            if (mispredict_c && stat_mispred_q != '1)
                stat_mispred_d = stat_mispred_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;
`else
    assign stat_branches = '0;
    assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: directed branches push expected results, a negedge monitor pops on each handshake.
module tb_branch_resolve;
    logic        clk, rst;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        ex_valid, ex_ready;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_rs1, ex_rs2, ex_pc, ex_imm;
    logic        ex_pred_taken, flush;
    logic        res_valid, res_ready, res_taken, res_mispredict;
    logic [31:0] res_target, res_redirect;
    logic [31:0] stat_branches, stat_mispred;

    typedef struct {
        logic        t;
        logic [31:0] tgt;
        logic [31:0] red;
        logic        m;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   exp_br = 0;
    int   exp_mis = 0;

    branch_resolve dut (
        .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_funct3(ex_funct3),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_pred_taken(ex_pred_taken), .flush(flush),
        .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
        .res_target(res_target), .res_redirect(res_redirect),
        .res_mispredict(res_mispredict),
        .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_stats(input string name);
`ifdef BRANCH_RESOLVE_STATS_EN
        chk({name, "_branches"}, stat_branches, exp_br);
        chk({name, "_mispred"}, stat_mispred, exp_mis);
`else
        chk({name, "_branches"}, stat_branches, 0);
        chk({name, "_mispred"}, stat_mispred, 0);
`endif
    endtask

    task automatic chk_pred(input string name, input logic [31:0] pc, input logic exp);
        pred_pc = pc;
        #1;
        chk(name, {31'd0, pred_taken}, {31'd0, exp});
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge with ex_valid low.
    task automatic send(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] pc, input logic [31:0] imm, input logic pred,
                        input logic e_t, input logic [31:0] e_tgt, input logic [31:0] e_red,
                        input logic e_m);
        exp_t e;
        bit   done = 0;
        ex_funct3 = f3; ex_rs1 = rs1; ex_rs2 = rs2;
        ex_pc = pc; ex_imm = imm; ex_pred_taken = pred;
        ex_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (ex_ready) begin
                e.t = e_t; e.tgt = e_tgt; e.red = e_red; e.m = e_m;
                sb.push_back(e);
                if (f3 != 3'b010 && f3 != 3'b011) begin
                    exp_br++;
                    if (e_m) exp_mis++;
                end
                done = 1;
            end
            @(posedge clk); #1;
        end
        ex_valid = 1'b0;
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got result target 0x%08h expected none", res_target);
            end else begin
                mon_e = sb.pop_front();
                chk("res_taken", {31'd0, res_taken}, {31'd0, mon_e.t});
                chk("res_target", res_target, mon_e.tgt);
                chk("res_redirect", res_redirect, mon_e.red);
                chk("res_mispredict", {31'd0, res_mispredict}, {31'd0, mon_e.m});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; res_ready = 1'b1; ex_valid = 1'b0; flush = 1'b0;
        ex_funct3 = 3'b000; ex_rs1 = '0; ex_rs2 = '0; ex_pc = '0; ex_imm = '0;
        ex_pred_taken = 1'b0; pred_pc = 32'h100;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_target", res_target, 32'd0);
        chk("rst_res_redirect", res_redirect, 32'd0);
        chk_pred("rst_pred_taken", 32'h100, 1'b0);
        chk_stats("rst_stats");
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_ex_ready", {31'd0, ex_ready}, 32'd1);

        // BEQ taken, trains entry 0 to 10
        send(3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 1'b1, 32'h120, 32'h120, 1'b1);
        chk_pred("beq_trained", 32'h100, 1'b1);
        // illegal funct3 must not train entry 0 down
        send(3'b011, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 1'b0, 32'h120, 32'h104, 1'b1);
        chk_pred("illegal_no_train", 32'h100, 1'b1);
        // signed vs unsigned compare of the same operands
        send(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h180, 32'h40, 1'b1, 1'b1, 32'h1C0, 32'h1C0, 1'b0);
        send(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b0, 1'b0, 32'h240, 32'h204, 1'b0);
        chk_pred("bltu_alias_down", 32'h100, 1'b0);
        @(posedge clk); #1;
        chk("drained_res_valid", {31'd0, res_valid}, 32'd0);

        // Back-pressure: result held while a new branch waits
        res_ready = 1'b0;
        send(3'b101, 32'd3, 32'd3, 32'h304, 32'h10, 1'b0, 1'b1, 32'h314, 32'h314, 1'b1);
        ex_funct3 = 3'b000; ex_rs1 = 32'd7; ex_rs2 = 32'd7;
        ex_pc = 32'h308; ex_imm = 32'h100; ex_pred_taken = 1'b1; ex_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_ex_ready", {31'd0, ex_ready}, 32'd0);
            chk("stall_res_valid", {31'd0, res_valid}, 32'd1);
            chk("stall_res_target", res_target, 32'h314);
            chk("stall_res_mispredict", {31'd0, res_mispredict}, 32'd1);
            @(posedge clk); #1;
        end
        chk_pred("stall_no_train", 32'h308, 1'b0);
        mon_e.t = 1'b1; mon_e.tgt = 32'h408; mon_e.red = 32'h408; mon_e.m = 1'b0;
        sb.push_back(mon_e);
        exp_br++;
        res_ready = 1'b1;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        chk("drain_accept_valid", {31'd0, res_valid}, 32'd1);
        chk("drain_accept_target", res_target, 32'h408);
        chk_pred("after_stall_train", 32'h308, 1'b1);
        @(posedge clk); #1;
        chk("drain_empty_valid", {31'd0, res_valid}, 32'd0);

        // Flush kills the pending result and the branch presented alongside it
        res_ready = 1'b0;
        send(3'b000, 32'd1, 32'd2, 32'h310, 32'h10, 1'b0, 1'b0, 32'h320, 32'h314, 1'b0);
        ex_funct3 = 3'b001; ex_rs1 = 32'd1; ex_rs2 = 32'd2;
        ex_pc = 32'h30C; ex_imm = 32'h10; ex_pred_taken = 1'b0;
        ex_valid = 1'b1; flush = 1'b1;
        void'(sb.pop_back());
        @(posedge clk); #1;
        ex_valid = 1'b0; flush = 1'b0;
        chk("flush_res_valid", {31'd0, res_valid}, 32'd0);
        chk_pred("flush_no_train", 32'h30C, 1'b0);
        chk_stats("flush_stats");
        res_ready = 1'b1;
        send(3'b001, 32'd1, 32'd2, 32'h30C, 32'h10, 1'b0, 1'b1, 32'h31C, 32'h31C, 1'b1);
        chk_pred("post_flush_train", 32'h30C, 1'b1);

        // Wrap-around target and counter saturation at 11
        send(3'b111, 32'd9, 32'd9, 32'hFFFF_FFF0, 32'h20, 1'b0, 1'b1, 32'h10, 32'h10, 1'b1);
        for (int i = 0; i < 3; i++)
            send(3'b111, 32'd9, 32'd9, 32'hFFFF_FFF0, 32'h20, 1'b1, 1'b1, 32'h10, 32'h10, 1'b0);
        chk_pred("sat_hi_taken", 32'hFFFF_FFF0, 1'b1);
        send(3'b111, 32'd1, 32'd9, 32'hFFFF_FFF0, 32'h20, 1'b1, 1'b0, 32'h10, 32'hFFFF_FFF4, 1'b1);
        chk_pred("sat_hi_one_down", 32'hFFFF_FFF0, 1'b1);
        send(3'b110, 32'd5, 32'd1, 32'hFFFF_FFFC, 32'h20, 1'b0, 1'b0, 32'h1C, 32'h0, 1'b0);
        @(posedge clk); #1;
        chk_stats("final_stats");

        // Reset with a pending result discards it and reinitialises the BHT
        res_ready = 1'b0;
        send(3'b000, 32'd4, 32'd4, 32'h400, 32'h8, 1'b0, 1'b1, 32'h408, 32'h408, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        exp_br = 0; exp_mis = 0;
        chk("midrst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("midrst_res_target", res_target, 32'd0);
        chk_pred("midrst_bht", 32'hFFFF_FFF0, 1'b0);
        chk_stats("midrst_stats");
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
